audio_sample_pacer: RTL and testbench

//  Downstream stage of the flash-read FSM pair. Accepts 32-bit words read from flash,

---
 rtl/audio_sample_pacer_if.sv | 26 ++
 rtl/audio_sample_pacer.sv | 188 ++++++++++++++++++
 tb/tb_audio_sample_pacer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_pacer_if.sv
// Audio sample pacer bus: control inputs, flash word handshake and paced audio outputs.
interface audio_sample_pacer_if;
  logic        play;
  logic        direction;
  logic        speed_up;
  logic        speed_down;
  logic        speed_reset;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic [7:0]  audio_out;
  logic        sample_strobe;
  logic        underrun;

  // Producer/controller side (fetcher and transport controls)
  modport master (
    output play, direction, speed_up, speed_down, speed_reset, word_valid, word_data,
    input  word_ready, audio_out, sample_strobe, underrun
  );

  // Pacer side
  modport slave (
    input  play, direction, speed_up, speed_down, speed_reset, word_valid, word_data,
    output word_ready, audio_out, sample_strobe, underrun
  );
endinterface

// File: rtl/audio_sample_pacer.sv
// Audio sample pacer: splits 32-bit flash words into two 16-bit PCM samples and
// emits their high bytes one per rate tick, with play/pause, order and speed control.
module audio_sample_pacer #(
  parameter int unsigned DEFAULT_DIV = 2272,
  parameter int unsigned DIV_STEP    = 64,
  parameter int unsigned MIN_DIV     = 256,
  parameter int unsigned MAX_DIV     = 8192,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_sample_pacer_if.slave  bus
);

  localparam logic [DIV_W-1:0] L_DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] L_STEP    = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0] L_MIN_DIV = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] L_MAX_DIV = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] L_ONE     = DIV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_FIRST  = 2'd2,
    S_SECOND = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;

  // Only the high byte of each half-word is ever played, so only those are buffered.
  logic [7:0]       r_hi_a;
  logic [7:0]       r_hi_b;
  logic             r_dir;
  logic [7:0]       r_audio;
  logic             r_strobe;
  logic             r_underrun;

  logic             w_ready;
  logic             w_accept;
  logic             w_emit_first;
  logic             w_emit_second;
  logic             w_underrun;
  logic [7:0]       w_first_byte;
  logic [7:0]       w_second_byte;
  logic             w_unused;

  // Low bytes of each sample are dropped by the 8-bit audio path.
  assign w_unused = ^{bus.word_data[23:16], bus.word_data[7:0]};

  // Rate tick: '>=' keeps the counter from running past a divider that just shrank.
  assign w_tick = bus.play && (r_cnt >= (r_div - L_ONE));

  // Sample rate counter, frozen while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.play) begin
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + L_ONE;
      end
    end
  end

  // Next divider: reset wins, opposing up/down cancel, result saturates to the legal range.
  always_comb begin
    w_div_nxt = r_div;
    if (bus.speed_reset) begin
      w_div_nxt = L_DEF_DIV;
    end else if (bus.speed_up && !bus.speed_down) begin
      if (r_div <= (L_MIN_DIV + L_STEP)) begin
        w_div_nxt = L_MIN_DIV;
      end else begin
        w_div_nxt = r_div - L_STEP;
      end
    end else if (bus.speed_down && !bus.speed_up) begin
      if (r_div >= (L_MAX_DIV - L_STEP)) begin
        w_div_nxt = L_MAX_DIV;
      end else begin
        w_div_nxt = r_div + L_STEP;
      end
    end
  end

  // Divider register; the new value is used by the tick compare from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= L_DEF_DIV;
    end else begin
      r_div <= w_div_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle actions; a tick in REQ that coincides with an accept is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = 1'b0;
    w_accept      = 1'b0;
    w_emit_first  = 1'b0;
    w_emit_second = 1'b0;
    w_underrun    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_ready = bus.play;
        if (bus.word_valid && bus.play) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FIRST;
        end else if (w_tick) begin
          w_underrun = 1'b1;
        end
      end
      S_FIRST: begin
        if (w_tick) begin
          w_emit_first = 1'b1;
          w_state_nxt  = S_SECOND;
        end
      end
      S_SECOND: begin
        if (w_tick) begin
          w_emit_second = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Half-word order: forward plays the low half first; the second pick uses the latched order.
  assign w_first_byte  = bus.direction ? r_hi_a : r_hi_b;
  assign w_second_byte = r_dir ? r_hi_b : r_hi_a;

  // Word buffer, captured only on an accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_a <= '0;
      r_hi_b <= '0;
    end else if (w_accept) begin
      r_hi_a <= bus.word_data[15:8];
      r_hi_b <= bus.word_data[31:24];
    end
  end

  // Audio output, strobe and underrun pulses, all registered one cycle after the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_audio    <= '0;
      r_dir      <= 1'b0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe   <= w_emit_first || w_emit_second;
      r_underrun <= w_underrun;
      if (w_emit_first) begin
        r_audio <= w_first_byte;
        r_dir   <= bus.direction;
      end else if (w_emit_second) begin
        r_audio <= w_second_byte;
      end
    end
  end

  assign bus.word_ready    = w_ready;
  assign bus.audio_out     = r_audio;
  assign bus.sample_strobe = r_strobe;
  assign bus.underrun      = r_underrun;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Scoreboard bench for audio_sample_pacer with a small divider configuration.
module tb_audio_sample_pacer;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  audio_sample_pacer_if bus();

  audio_sample_pacer #(
    .DEFAULT_DIV(8),
    .DIV_STEP   (2),
    .MIN_DIV    (4),
    .MAX_DIV    (12),
    .DIV_W      (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe pops the next expected sample.
  always @(negedge clk) begin
    if (!rst && bus.sample_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%0h required=none @%0t", bus.audio_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("audio_out", 32'(bus.audio_out), 32'(e));
      end
    end
  end

  // Returns number of negedges until a strobe is seen.
  task automatic wait_strobe(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.sample_strobe) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout actual=none required=strobe_within_%0d @%0t", budget, $time);
    end
  endtask

  task automatic wait_underrun(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.underrun) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL underrun_timeout actual=none required=underrun_within_%0d @%0t", budget, $time);
    end
  endtask

  // Called at a negedge; offers a word until accepted.
  task automatic send_word(input logic [31:0] data);
    bit ok;
    ok = 1'b1;
    bus.word_data  = data;
    bus.word_valid = 1'b1;
    if (!bus.word_ready) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.word_ready) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready @%0t", $time);
    end
    @(posedge clk);
    #1 bus.word_valid = 1'b0;
  endtask

  // Tick period measured between two consecutive underrun pulses.
  task automatic measure_period(input string name, input int exp);
    int n;
    wait_underrun(40, n);
    wait_underrun(40, n);
    check(name, 32'(n), 32'(exp));
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.speed_up = 1'b1;
    else if (which == 1) bus.speed_down = 1'b1;
    else if (which == 2) begin
      bus.speed_up   = 1'b1;
      bus.speed_down = 1'b1;
    end else bus.speed_reset = 1'b1;
    @(negedge clk);
    bus.speed_up    = 1'b0;
    bus.speed_down  = 1'b0;
    bus.speed_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ur;
    int st;
    int up_exp[3];
    int dn_exp[5];
    up_exp = '{6, 4, 4};
    dn_exp = '{6, 8, 10, 12, 12};

    rst             = 1'b1;
    bus.play        = 1'b0;
    bus.direction   = 1'b1;
    bus.speed_up    = 1'b0;
    bus.speed_down  = 1'b0;
    bus.speed_reset = 1'b0;
    bus.word_valid  = 1'b0;
    bus.word_data   = '0;
    repeat (3) @(negedge clk);
    check("reset_ready",     32'(bus.word_ready),    32'd0);
    check("reset_audio",     32'(bus.audio_out),     32'd0);
    check("reset_strobe",    32'(bus.sample_strobe), 32'd0);
    check("reset_underrun",  32'(bus.underrun),      32'd0);
    rst      = 1'b0;
    bus.play = 1'b1;
    @(negedge clk);

    // Forward order: low half first
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA1);
    send_word(32'hA1B2_C3D4);
    wait_strobe(40, n);
    wait_strobe(40, n);
    check("t1_strobe_spacing", 32'(n), 32'd8);
    check("t1_ready_after",    32'(bus.word_ready), 32'd1);

    // Backward order; direction flip after first sample must not affect second
    bus.direction = 1'b0;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hC3);
    send_word(32'hA1B2_C3D4);
    wait_strobe(40, n);
    bus.direction = 1'b1;
    wait_strobe(40, n);
    check("t2_strobe_spacing", 32'(n), 32'd8);
    check("t2_ready_after",    32'(bus.word_ready), 32'd1);

    // Starved in REQ for 20 clocks
    ur = 0;
    st = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.underrun) ur++;
      if (bus.sample_strobe) st++;
    end
    check("t3_underruns",   32'(ur), 32'd2);
    check("t3_no_strobe",   32'(st), 32'd0);
    check("t3_audio_held",  32'(bus.audio_out), 32'hC3);
    measure_period("t3_period", 8);

    // Divider steps and saturation
    for (int i = 0; i < 3; i++) begin
      pulse(0);
      measure_period($sformatf("t4_up%0d", i), up_exp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      pulse(1);
      measure_period($sformatf("t4_down%0d", i), dn_exp[i]);
    end
    pulse(2);
    measure_period("t4_up_down_same", 12);
    pulse(3);
    measure_period("t4_speed_reset", 8);

    // Pause for 30 clocks in FIRST, two cycles after accept
    wait_underrun(40, n);
    bus.direction = 1'b1;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h11);
    send_word(32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    bus.play = 1'b0;
    st = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.sample_strobe) st++;
    end
    check("t5_pause_no_strobe", 32'(st), 32'd0);
    check("t5_pause_ready",     32'(bus.word_ready), 32'd0);
    bus.play = 1'b1;
    wait_strobe(40, n);
    check("t5_resume_remaining", 32'(n), 32'd6);
    wait_strobe(40, n);
    check("t5_second_spacing", 32'(n), 32'd8);

    // Pause in REQ: no underrun, not ready
    bus.play = 1'b0;
    ur = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.underrun) ur++;
    end
    check("req_pause_underrun", 32'(ur), 32'd0);
    check("req_pause_ready",    32'(bus.word_ready), 32'd0);
    bus.play = 1'b1;
    @(negedge clk);

    // Reset in SECOND discards the pending sample
    exp_q.push_back(8'h77);
    send_word(32'h5566_7788);
    wait_strobe(40, n);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_audio",  32'(bus.audio_out),     32'd0);
    check("t6_rst_strobe", 32'(bus.sample_strobe), 32'd0);
    check("t6_rst_ready",  32'(bus.word_ready),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_idle_ready", 32'(bus.word_ready), 32'd0);
    @(negedge clk);
    check("t6_req_ready",  32'(bus.word_ready), 32'd1);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h55);
    send_word(32'h5566_7788);
    wait_strobe(40, n);
    wait_strobe(40, n);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
